result_sram_reader: RTL and testbench

Drain engine for the results SRAM: after a vector-multiply pass has written 32-lane partial-sum rows into the results buffer, this block reads a programmed range of rows back and serializes each row into one 24-bit lane per beat over a valid/ready stream. It sits between the results SRAM read port and the host/output interface.

---
 rtl/result_sram_reader_if.sv | 37 +++
 rtl/result_sram_reader.sv | 137 +++++++++++++
 tb/tb_result_sram_reader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_sram_reader_if.sv
// Bundle of the drain engine's control, SRAM read port and output stream.
// The reader uses the master side; the SRAM/host environment uses the slave side.
interface result_sram_reader_if #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 32
);
  localparam int LANE_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  // drain request
  logic                                   start;
  logic [ADDRESSSIZE-1:0]                 base_addr;
  logic [ADDRESSSIZE:0]                   num_rows;
  // results SRAM read port
  logic                                   sram_read_en;
  logic [ADDRESSSIZE-1:0]                 sram_read_address;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_read_data;
  // lane stream
  logic                                   m_valid;
  logic                                   m_ready;
  logic [PARTIAL_SUM_BW-1:0]              m_data;
  logic [LANE_W-1:0]                      m_lane;
  logic                                   m_last;
  // status
  logic                                   busy;
  logic                                   done;

  modport master (
    input  start, base_addr, num_rows, sram_read_data, m_ready,
    output sram_read_en, sram_read_address, m_valid, m_data, m_lane, m_last, busy, done
  );

  modport slave (
    output start, base_addr, num_rows, sram_read_data, m_ready,
    input  sram_read_en, sram_read_address, m_valid, m_data, m_lane, m_last, busy, done
  );
endinterface

// File: rtl/result_sram_reader.sv
// Results SRAM drain engine: reads a range of 32-lane partial-sum rows and
// serializes each row, lane 0 first, onto a valid/ready stream.
module result_sram_reader #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  result_sram_reader_if.master   bus
);
  localparam int LANE_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int ROW_W  = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(MATRIX_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                    state_reg;
  logic [ADDRESSSIZE-1:0]    addr_reg;
  logic [ADDRESSSIZE:0]      rows_left_reg;
  logic [ROW_W-1:0]          row_reg;
  logic [LANE_W-1:0]         lane_reg;
  logic                      read_en_reg;
  logic                      m_valid_reg;
  logic [PARTIAL_SUM_BW-1:0] m_data_reg;
  logic                      m_last_reg;
  logic                      busy_reg;
  logic                      done_reg;

  // Row register viewed as an array of lanes so the next beat is a plain index.
  logic [PARTIAL_SUM_BW-1:0] row_lanes [MATRIX_SIZE];
  genvar gi;
  generate
    for (gi = 0; gi < MATRIX_SIZE; gi++) begin : g_lane
      assign row_lanes[gi] = row_reg[gi*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    end
  endgenerate

  logic              handshake;
  logic              final_row;
  logic [LANE_W-1:0] next_lane;

  assign handshake = m_valid_reg && bus.m_ready;
  assign final_row = (rows_left_reg == (ADDRESSSIZE+1)'(1));
  assign next_lane = lane_reg + 1'b1;

  // Drain sequencer; every output is a register updated with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      rows_left_reg <= '0;
      row_reg       <= '0;
      lane_reg      <= '0;
      read_en_reg   <= 1'b0;
      m_valid_reg   <= 1'b0;
      m_data_reg    <= '0;
      m_last_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      read_en_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            addr_reg      <= bus.base_addr;
            rows_left_reg <= bus.num_rows;
            busy_reg      <= 1'b1;
            if (bus.num_rows == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg   <= S_FETCH;
              read_en_reg <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          // read strobe is up this cycle; data arrives during WAIT
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          row_reg     <= bus.sram_read_data;
          lane_reg    <= '0;
          m_valid_reg <= 1'b1;
          m_data_reg  <= bus.sram_read_data[PARTIAL_SUM_BW-1:0];
          m_last_reg  <= final_row && (LAST_LANE == '0);
          state_reg   <= S_STREAM;
        end
        S_STREAM: begin
          if (handshake) begin
            if (lane_reg == LAST_LANE) begin
              m_valid_reg <= 1'b0;
              m_last_reg  <= 1'b0;
              if (final_row) begin
                state_reg <= S_DONE;
                done_reg  <= 1'b1;
              end else begin
                addr_reg      <= addr_reg + 1'b1;
                rows_left_reg <= rows_left_reg - 1'b1;
                read_en_reg   <= 1'b1;
                state_reg     <= S_FETCH;
              end
            end else begin
              lane_reg   <= next_lane;
              m_data_reg <= row_lanes[next_lane];
              m_last_reg <= final_row && (next_lane == LAST_LANE);
            end
          end
        end
        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sram_read_en      = read_en_reg;
  assign bus.sram_read_address = addr_reg;
  assign bus.m_valid           = m_valid_reg;
  assign bus.m_data            = m_data_reg;
  assign bus.m_lane            = lane_reg;
  assign bus.m_last            = m_last_reg;
  assign bus.busy              = busy_reg;
  assign bus.done              = done_reg;
endmodule

// File: tb/tb_result_sram_reader.sv
// Testbench for result_sram_reader: behavioural SRAM, lane-level reference model.
module tb_result_sram_reader;
  localparam int AW = 10;
  localparam int BW = 24;
  localparam int MS = 32;

  logic clk;
  logic rst;

  result_sram_reader_if #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(BW), .MATRIX_SIZE(MS)) bus ();

  result_sram_reader #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(BW), .MATRIX_SIZE(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents kept as lanes; the row word is assembled on read.
  logic [BW-1:0] lane_mem [0:1023][0:MS-1];

  always @(posedge clk) begin
    if (bus.sram_read_en) begin
      for (int k = 0; k < MS; k++)
        bus.sram_read_data[k*BW +: BW] <= lane_mem[bus.sram_read_address][k];
    end
  end

  int checks = 0;
  int passed = 0;

  // observations from one drain
  logic [BW-1:0] obs_data[$];
  int            obs_lane[$];
  bit            obs_last[$];
  int            obs_cyc[$];
  int            rd_addr[$];
  int            rd_cyc[$];
  int            done_cyc, done_count, stall_bad;
  logic          busy1, busy_after;
  bit            timed_out;

  // reference beats
  logic [BW-1:0] exp_data[$];
  int            exp_lane[$];
  bit            exp_last[$];

  task automatic build_expected(input int base, input int n);
    exp_data.delete(); exp_lane.delete(); exp_last.delete();
    for (int r = 0; r < n; r++)
      for (int k = 0; k < MS; k++) begin
        exp_data.push_back(lane_mem[(base + r) % 1024][k]);
        exp_lane.push_back(k);
        exp_last.push_back((r == n - 1) && (k == MS - 1));
      end
  endtask

  // Starts a drain and records everything the DUT does until done (cycle 1 = T+1).
  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic collect(input int base, input int n, input int mode, input int pulse_c);
    int c;
    bit finished;
    bit prev_stall;
    logic [BW-1:0] pd;
    int pl;
    bit plast;
    obs_data.delete(); obs_lane.delete(); obs_last.delete(); obs_cyc.delete();
    rd_addr.delete(); rd_cyc.delete();
    done_cyc = -1; done_count = 0; stall_bad = 0; busy1 = 1'bx; busy_after = 1'bx;
    prev_stall = 0; pd = '0; pl = 0; plast = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = AW'(base); bus.num_rows = (AW+1)'(n); bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1; finished = 0;
    while (!finished && c <= 3000) begin
      case (mode)
        0: bus.m_ready = 1'b1;
        1: bus.m_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      bus.start = (c == pulse_c);
      if (c == pulse_c) begin bus.base_addr = 10'd0; bus.num_rows = 11'd7; end
      if (c == 1) busy1 = bus.busy;
      if (bus.sram_read_en) begin rd_addr.push_back(int'(bus.sram_read_address)); rd_cyc.push_back(c); end
      if (prev_stall && (!bus.m_valid || bus.m_data !== pd || int'(bus.m_lane) != pl || bus.m_last !== plast))
        stall_bad++;
      prev_stall = bus.m_valid && !bus.m_ready;
      pd = bus.m_data; pl = int'(bus.m_lane); plast = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        obs_data.push_back(bus.m_data); obs_lane.push_back(int'(bus.m_lane));
        obs_last.push_back(bus.m_last); obs_cyc.push_back(c);
      end
      if (bus.done) begin done_cyc = c; done_count++; end
      @(negedge clk);
      bus.start = 1'b0;
      if (done_cyc >= 0) begin busy_after = bus.busy; finished = 1; end
      c++;
    end
    timed_out = !finished;
    bus.m_ready = 1'b1;
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.sram_read_en, bus.sram_read_address, bus.m_valid, bus.m_data, bus.m_lane, bus.m_last, bus.busy, bus.done} !== '0)
      $display("FAIL reset_outputs: got en=%b addr=%0d valid=%b data=%h lane=%0d last=%b busy=%b done=%b, expected all 0",
               bus.sram_read_en, bus.sram_read_address, bus.m_valid, bus.m_data, bus.m_lane, bus.m_last, bus.busy, bus.done);
    else passed++;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) $display("FAIL idle_after_reset: busy=%b valid=%b, expected 0 0", bus.busy, bus.m_valid);
    else passed++;
    $display("reset: done");
  endtask

  task automatic test_single_row;
    for (int k = 0; k < MS; k++) lane_mem[5][k] = BW'(k + 1);
    collect(5, 1, 0, 0);
    build_expected(5, 1);
    checks++;
    if (rd_addr.size() != 1 || rd_addr[0] != 5 || rd_cyc[0] != 1)
      $display("FAIL single_read: got %0d reads first addr=%0d cyc=%0d, expected 1 read addr=5 cyc=1",
               rd_addr.size(), (rd_addr.size() > 0) ? rd_addr[0] : -1, (rd_cyc.size() > 0) ? rd_cyc[0] : -1);
    else passed++;
    checks++;
    if (obs_data.size() != MS) $display("FAIL single_count: got %0d beats, expected %0d", obs_data.size(), MS);
    else passed++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_lane[i] != exp_lane[i] || obs_last[i] != exp_last[i] || obs_cyc[i] != 3 + i)
        $display("FAIL single_beat%0d: got data=%h lane=%0d last=%0b cyc=%0d, expected data=%h lane=%0d last=%0b cyc=%0d",
                 i, obs_data[i], obs_lane[i], obs_last[i], obs_cyc[i], exp_data[i], exp_lane[i], exp_last[i], 3 + i);
      else passed++;
    end
    checks++;
    if (done_cyc != 35 || busy1 !== 1'b1 || busy_after !== 1'b0)
      $display("FAIL single_done: got done_cyc=%0d busy1=%b busy_after=%b, expected 35 1 0", done_cyc, busy1, busy_after);
    else passed++;
    $display("single_row: %0d beats, done at T+%0d", obs_data.size(), done_cyc);
  endtask

  task automatic test_signed;
    for (int k = 0; k < MS; k++) lane_mem[100][k] = BW'($urandom);
    lane_mem[100][0] = 24'hFFFFFF;
    lane_mem[100][MS-1] = 24'h800000;
    collect(100, 1, 0, 0);
    build_expected(100, 1);
    checks++;
    if (obs_data.size() != MS || obs_data[0] !== 24'hFFFFFF || obs_data[MS-1] !== 24'h800000)
      $display("FAIL signed_ends: got %0d beats first=%h last=%h, expected %0d beats ffffff 800000",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 'x, (obs_data.size() == MS) ? obs_data[MS-1] : 'x, MS);
    else passed++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_lane[i] != exp_lane[i] || obs_last[i] != exp_last[i])
        $display("FAIL signed_beat%0d: got data=%h lane=%0d last=%0b, expected data=%h lane=%0d last=%0b",
                 i, obs_data[i], obs_lane[i], obs_last[i], exp_data[i], exp_lane[i], exp_last[i]);
      else passed++;
    end
    $display("signed: %0d beats", obs_data.size());
  endtask

  task automatic test_backpressure;
    collect(200, 2, 1, 0);
    build_expected(200, 2);
    checks++;
    if (obs_data.size() != 2 * MS || stall_bad != 0 || done_count != 1)
      $display("FAIL bp_summary: got beats=%0d stall_changes=%0d dones=%0d, expected %0d 0 1", obs_data.size(), stall_bad, done_count, 2 * MS);
    else passed++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_lane[i] != exp_lane[i] || obs_last[i] != exp_last[i])
        $display("FAIL bp_beat%0d: got data=%h lane=%0d last=%0b, expected data=%h lane=%0d last=%0b",
                 i, obs_data[i], obs_lane[i], obs_last[i], exp_data[i], exp_lane[i], exp_last[i]);
      else passed++;
    end
    $display("backpressure: %0d beats accepted, done at T+%0d", obs_data.size(), done_cyc);
  endtask

  task automatic test_wrap;
    collect(1023, 2, 0, 0);
    build_expected(1023, 2);
    checks++;
    if (rd_addr.size() != 2 || rd_addr[0] != 1023 || rd_addr[1] != 0 || rd_cyc[1] != MS + 3)
      $display("FAIL wrap_reads: got %0d reads addrs=%0d,%0d second_cyc=%0d, expected 1023,0 at %0d", rd_addr.size(),
               (rd_addr.size() > 0) ? rd_addr[0] : -1, (rd_addr.size() > 1) ? rd_addr[1] : -1,
               (rd_cyc.size() > 1) ? rd_cyc[1] : -1, MS + 3);
    else passed++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_lane[i] != exp_lane[i] || obs_last[i] != exp_last[i])
        $display("FAIL wrap_beat%0d: got data=%h lane=%0d last=%0b, expected data=%h lane=%0d last=%0b",
                 i, obs_data[i], obs_lane[i], obs_last[i], exp_data[i], exp_lane[i], exp_last[i]);
      else passed++;
    end
    checks++;
    if (obs_data.size() != 2 * MS || done_cyc != 2 * (MS + 2) + 1)
      $display("FAIL wrap_done: got beats=%0d done_cyc=%0d, expected %0d %0d", obs_data.size(), done_cyc, 2 * MS, 2 * (MS + 2) + 1);
    else passed++;
    $display("wrap: reads %0d, done at T+%0d", rd_addr.size(), done_cyc);
  endtask

  task automatic test_zero_and_ignored;
    collect(7, 0, 0, 0);
    checks++;
    if (done_cyc != 1 || rd_addr.size() != 0 || obs_data.size() != 0 || busy1 !== 1'b1 || busy_after !== 1'b0)
      $display("FAIL zero_rows: got done_cyc=%0d reads=%0d beats=%0d busy1=%b busy_after=%b, expected 1 0 0 1 0",
               done_cyc, rd_addr.size(), obs_data.size(), busy1, busy_after);
    else passed++;
    collect(300, 2, 0, 20);
    build_expected(300, 2);
    checks++;
    if (obs_data.size() != 2 * MS || done_count != 1 || done_cyc != 2 * (MS + 2) + 1 || rd_addr.size() != 2)
      $display("FAIL ignored_start: got beats=%0d dones=%0d done_cyc=%0d reads=%0d, expected %0d 1 %0d 2",
               obs_data.size(), done_count, done_cyc, rd_addr.size(), 2 * MS, 2 * (MS + 2) + 1);
    else passed++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_lane[i] != exp_lane[i] || obs_last[i] != exp_last[i])
        $display("FAIL ignored_beat%0d: got data=%h lane=%0d last=%0b, expected data=%h lane=%0d last=%0b",
                 i, obs_data[i], obs_lane[i], obs_last[i], exp_data[i], exp_lane[i], exp_last[i]);
      else passed++;
    end
    // nothing may have been queued by the mid-drain start
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL ignored_no_queue: busy=%b, expected 0", bus.busy);
    else passed++;
    $display("zero_and_ignored: zero-row done at T+%0d, second drain %0d beats", 1, obs_data.size());
  endtask

  task automatic test_reset_mid_stream;
    bit found;
    bit saw_done;
    bit saw_valid;
    found = 0; saw_done = 0; saw_valid = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 10'd400; bus.num_rows = 11'd2; bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.m_valid && bus.m_lane == 5'd9) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) $display("FAIL rst_reach_beat10: lane 9 not seen within 100 cycles, expected it");
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.sram_read_en, bus.sram_read_address, bus.m_valid, bus.m_data, bus.m_lane, bus.m_last, bus.busy, bus.done} !== '0)
      $display("FAIL rst_mid_outputs: got en=%b addr=%0d valid=%b data=%h lane=%0d last=%b busy=%b done=%b, expected all 0",
               bus.sram_read_en, bus.sram_read_address, bus.m_valid, bus.m_data, bus.m_lane, bus.m_last, bus.busy, bus.done);
    else passed++;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
      if (bus.m_valid) saw_valid = 1;
    end
    checks++;
    if (saw_done || saw_valid) $display("FAIL rst_abandon: got done=%0b valid=%0b after reset, expected 0 0", saw_done, saw_valid);
    else passed++;
    collect(400, 1, 0, 0);
    build_expected(400, 1);
    checks++;
    if (obs_data.size() != MS || done_cyc != MS + 3)
      $display("FAIL rst_redrain: got beats=%0d done_cyc=%0d, expected %0d %0d", obs_data.size(), done_cyc, MS, MS + 3);
    else passed++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_lane[i] != exp_lane[i] || obs_last[i] != exp_last[i])
        $display("FAIL redrain_beat%0d: got data=%h lane=%0d last=%0b, expected data=%h lane=%0d last=%0b",
                 i, obs_data[i], obs_lane[i], obs_last[i], exp_data[i], exp_lane[i], exp_last[i]);
      else passed++;
    end
    $display("reset_mid_stream: redrain %0d beats, done at T+%0d", obs_data.size(), done_cyc);
  endtask

  task automatic test_random;
    for (int t = 0; t < 4; t++) begin
      int base;
      int n;
      base = $urandom_range(0, 1023);
      n = $urandom_range(1, 3);
      collect(base, n, 2, 0);
      build_expected(base, n);
      checks++;
      if (timed_out || obs_data.size() != n * MS || rd_addr.size() != n || stall_bad != 0 ||
          obs_cyc.size() == 0 || done_cyc != obs_cyc[obs_cyc.size()-1] + 1)
        $display("FAIL rand%0d_summary: got timeout=%0b beats=%0d reads=%0d stall_changes=%0d done_cyc=%0d, expected 0 %0d %0d 0 last_beat+1",
                 t, timed_out, obs_data.size(), rd_addr.size(), stall_bad, done_cyc, n * MS, n);
      else passed++;
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
        checks++;
        if (obs_data[i] !== exp_data[i] || obs_lane[i] != exp_lane[i] || obs_last[i] != exp_last[i])
          $display("FAIL rand%0d_beat%0d: got data=%h lane=%0d last=%0b, expected data=%h lane=%0d last=%0b",
                   t, i, obs_data[i], obs_lane[i], obs_last[i], exp_data[i], exp_lane[i], exp_last[i]);
        else passed++;
      end
      $display("random %0d: base=%0d rows=%0d beats=%0d done at T+%0d", t, base, n, obs_data.size(), done_cyc);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0; bus.m_ready = 1'b0;
    for (int a = 0; a < 1024; a++)
      for (int k = 0; k < MS; k++) lane_mem[a][k] = BW'($urandom);
    repeat (3) @(negedge clk);
    test_reset;
    test_single_row;
    test_signed;
    test_backpressure;
    test_wrap;
    test_zero_and_ignored;
    test_reset_mid_stream;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
